// File: rtl/mult_seq.sv
// Sequencer for a 2x2-tile int8 matrix multiply (N = 2..5), feeding an external tile datapath.
// Latency: ceil(N/2)^2 * (4+MULT_LAT) cycles from start accept to done; a/b memory reads return one cycle later.
// Backpressure: none; start is ignored while busy and abort returns to IDLE on the next cycle.
module mult_seq #(
    parameter int unsigned MULT_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [2:0]  size,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        ovf_flag,
    output logic [2:0]  a_addr,
    output logic [2:0]  b_addr,
    output logic        rd_en,
    input  logic [39:0] a_data,
    input  logic [39:0] b_data,
    output logic [79:0] lin,
    output logic [79:0] col,
    output logic        dp_clr,
    input  logic [31:0] n_out,
    input  logic        ovf,
    output logic        wr_en,
    output logic [3:0]  wr_tile,
    output logic [31:0] wr_data
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH_A, S_FETCH_B, S_LOAD, S_WAIT, S_WRITE, S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_size;
    logic [1:0]  r_rp;
    logic [1:0]  r_cp;
    logic [2:0]  r_wcnt;
    logic [79:0] r_lin;
    logic [79:0] r_col;
    logic        r_ovf_flag;

    logic        w_size_ok;
    logic [1:0]  w_last;
    logic        w_row_last;
    logic        w_tile_last;
    logic        w_wait_end;
    logic [2:0]  w_odd_a;
    logic [2:0]  w_odd_b;

    // Keep only bytes 0..n-1 (byte 0 in the top bits); a row/column beyond N becomes all zero.
    function automatic logic [39:0] mask_vec(input logic [39:0] d, input logic keep,
                                             input logic [2:0] n);
        logic [39:0] m;
        m = '0;
        for (int k = 0; k < 5; k++) begin
            if (keep && (3'(k) < n)) m[39-8*k -: 8] = d[39-8*k -: 8];
        end
        return m;
    endfunction

    assign w_size_ok   = (size >= 3'd2) && (size <= 3'd5);
    assign w_last      = 2'((r_size - 3'd1) >> 1);
    assign w_row_last  = (r_cp == w_last);
    assign w_tile_last = w_row_last && (r_rp == w_last);
    assign w_wait_end  = (r_wcnt == 3'(MULT_LAT - 1));
    assign w_odd_a     = {r_rp, 1'b1};
    assign w_odd_b     = {r_cp, 1'b1};

    assign busy     = (r_state != S_IDLE);
    assign ovf_flag = r_ovf_flag;
    assign lin      = r_lin;
    assign col      = r_col;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (start && w_size_ok) w_next = S_FETCH_A;
            S_FETCH_A: w_next = S_FETCH_B;
            S_FETCH_B: w_next = S_LOAD;
            S_LOAD:    w_next = S_WAIT;
            S_WAIT:    if (w_wait_end) w_next = S_WRITE;
            S_WRITE:   w_next = w_tile_last ? S_DONE : S_FETCH_A;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
        if (abort && (r_state != S_IDLE)) w_next = S_IDLE;
    end

    always_comb begin
        a_addr  = '0;
        b_addr  = '0;
        rd_en   = 1'b0;
        dp_clr  = 1'b0;
        wr_en   = 1'b0;
        wr_tile = '0;
        wr_data = '0;
        done    = 1'b0;
        err     = 1'b0;
        case (r_state)
            S_IDLE:    err = start && !w_size_ok;
            S_FETCH_A: begin
                a_addr = {r_rp, 1'b0};
                b_addr = {r_cp, 1'b0};
                rd_en  = 1'b1;
                dp_clr = 1'b1;
            end
            S_FETCH_B: begin
                a_addr = w_odd_a;
                b_addr = w_odd_b;
                rd_en  = 1'b1;
            end
            S_WRITE: begin
                wr_en   = 1'b1;
                wr_tile = {2'b00, r_rp} * 4'd3 + {2'b00, r_cp};
                wr_data = n_out;
            end
            S_DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_size     <= '0;
            r_rp       <= '0;
            r_cp       <= '0;
            r_wcnt     <= '0;
            r_lin      <= '0;
            r_col      <= '0;
            r_ovf_flag <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && w_size_ok) begin
                        r_size     <= size;
                        r_rp       <= '0;
                        r_cp       <= '0;
                        r_ovf_flag <= 1'b0;
                    end
                end
                S_FETCH_B: begin
                    r_lin[79:40] <= mask_vec(a_data, 1'b1, r_size);
                    r_col[79:40] <= mask_vec(b_data, 1'b1, r_size);
                end
                S_LOAD: begin
                    r_lin[39:0] <= mask_vec(a_data, w_odd_a < r_size, r_size);
                    r_col[39:0] <= mask_vec(b_data, w_odd_b < r_size, r_size);
                    r_wcnt      <= '0;
                end
                S_WAIT:  r_wcnt <= r_wcnt + 3'd1;
                S_WRITE: begin
                    r_ovf_flag <= r_ovf_flag | ovf;
                    if (w_row_last) begin
                        r_cp <= '0;
                        r_rp <= r_rp + 2'd1;
                    end else begin
                        r_cp <= r_cp + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq.sv
// Bench for mult_seq: behavioural a/b memories and tile datapath, scoreboard of expected tile writes.
module tb_mult_seq;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [2:0]  size;
    logic        busy, done, err, ovf_flag;
    logic [2:0]  a_addr, b_addr;
    logic        rd_en;
    logic [39:0] a_data, b_data;
    logic [79:0] lin, col;
    logic        dp_clr;
    logic [31:0] n_out;
    logic        ovf;
    logic        wr_en;
    logic [3:0]  wr_tile;
    logic [31:0] wr_data;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    logic [31:0] last_wr_data;

    int          ma[5][5];
    int          mb[5][5];
    logic [39:0] mem_a[8];
    logic [39:0] mem_b[8];
    logic [35:0] sb[$];
    logic [35:0] sb_exp;
    logic [35:0] sb_got;
    logic        exp_ovf;
    logic [32:0] pipe[LAT];

    mult_seq #(.MULT_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .size(size),
        .busy(busy), .done(done), .err(err), .ovf_flag(ovf_flag),
        .a_addr(a_addr), .b_addr(b_addr), .rd_en(rd_en),
        .a_data(a_data), .b_data(b_data),
        .lin(lin), .col(col), .dp_clr(dp_clr), .n_out(n_out), .ovf(ovf),
        .wr_en(wr_en), .wr_tile(wr_tile), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en) begin
            a_data <= mem_a[a_addr];
            b_data <= mem_b[b_addr];
        end
    end

    // Tile datapath: int8 dot products, truncated to 8 bits, overflow if any sum leaves int8 range.
    function automatic logic [32:0] dp_model(input logic [79:0] l, input logic [79:0] c);
        logic [32:0] r;
        int s, x, y;
        r = '0;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                s = 0;
                for (int k = 0; k < 5; k++) begin
                    x = int'($signed(l[79-40*i-8*k -: 8]));
                    y = int'($signed(c[79-40*j-8*k -: 8]));
                    s += x * y;
                end
                r[31-8*(2*i+j) -: 8] = s[7:0];
                if (s > 127 || s < -128) r[32] = 1'b1;
            end
        end
        return r;
    endfunction

    always @(posedge clk) begin
        pipe[0] <= dp_model(lin, col);
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign {ovf, n_out} = pipe[LAT-1];

    always @(negedge clk) begin
        if (wr_en) begin
            wr_cnt++;
            last_wr_data = wr_data;
            sb_got = {wr_tile, wr_data};
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_write unexpected: tile=%0d data=%h, none expected", wr_tile, wr_data);
            end else begin
                sb_exp = sb.pop_front();
                if (sb_got !== sb_exp) begin
                    errors++;
                    $display("FAIL sb_write got tile=%0d data=%h, expected tile=%0d data=%h",
                             sb_got[35:32], sb_got[31:0], sb_exp[35:32], sb_exp[31:0]);
                end
            end
        end
    end

    // Memories hold 0xA5 junk in every byte outside the N x N matrix.
    task automatic load_mem(input int n);
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 5; k++) begin
                mem_a[r][39-8*k -: 8] = (r < n && k < n) ? 8'(ma[r][k]) : 8'hA5;
                mem_b[r][39-8*k -: 8] = (r < n && k < n) ? 8'(mb[k][r]) : 8'hA5;
            end
        end
    endtask

    task automatic push_exp(input int n, input int ntiles);
        int t, cnt, s, r, c;
        logic [31:0] d;
        t = (n + 1) / 2;
        cnt = 0;
        for (int rp = 0; rp < t; rp++) begin
            for (int cp = 0; cp < t; cp++) begin
                d = '0;
                for (int i = 0; i < 2; i++) begin
                    for (int j = 0; j < 2; j++) begin
                        r = 2 * rp + i;
                        c = 2 * cp + j;
                        if (r < n && c < n) begin
                            s = 0;
                            for (int k = 0; k < n; k++) s += ma[r][k] * mb[k][c];
                            if (s > 127 || s < -128) exp_ovf = 1'b1;
                            d[31-8*(2*i+j) -: 8] = s[7:0];
                        end
                    end
                end
                if (cnt < ntiles) sb.push_back({4'(rp * 3 + cp), d});
                cnt++;
            end
        end
    endtask

    task automatic fill_rand(input int n);
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < 5; k++) begin
                ma[r][k] = (r < n && k < n) ? int'($urandom_range(0, 6)) - 3 : 0;
                mb[r][k] = (r < n && k < n) ? int'($urandom_range(0, 6)) - 3 : 0;
            end
        end
    endtask

    task automatic run_op(input int n, input bit hold, output int first_wr, output int done_at,
                          output int nwr);
        int w0;
        w0 = wr_cnt;
        first_wr = -1;
        done_at = -1;
        start = 1'b1;
        size = 3'(n);
        for (int rel = 1; rel <= 200; rel++) begin
            @(negedge clk);
            if (hold) size = 3'd7;
            else      start = 1'b0;
            if (wr_en && first_wr < 0) first_wr = rel;
            if (done) begin
                done_at = rel;
                break;
            end
        end
        start = 1'b0;
        @(negedge clk);
        nwr = wr_cnt - w0;
    endtask

    task automatic test_reset;
        rst = 1'b0; start = 1'b0; abort = 1'b0; size = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, err, rd_en, wr_en, dp_clr, ovf_flag} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b, expected 0000000", {busy, done, err, rd_en, wr_en, dp_clr, ovf_flag});
        end
        checks++;
        if ({lin, col} !== 160'b0) begin
            errors++;
            $display("FAIL reset_lincol got lin=%h col=%h, expected 0", lin, col);
        end
        checks++;
        if ({a_addr, b_addr, wr_tile, wr_data} !== 42'b0) begin
            errors++;
            $display("FAIL reset_addr got a=%0d b=%0d tile=%0d data=%h, expected 0", a_addr, b_addr, wr_tile, wr_data);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_busy got %b, expected 0", busy);
        end
    endtask

    task automatic test_basic;
        int w0;
        ma[0][0] = 1; ma[0][1] = 2; ma[1][0] = 3; ma[1][1] = 4;
        mb[0][0] = 5; mb[0][1] = 6; mb[1][0] = 7; mb[1][1] = 8;
        load_mem(2);
        exp_ovf = 1'b0;
        push_exp(2, 9);
        w0 = wr_cnt;
        start = 1'b1; size = 3'd2;
        for (int rel = 1; rel <= 9; rel++) begin
            @(negedge clk);
            start = 1'b0;
            if (rel == 1) begin
                checks++;
                if ({a_addr, b_addr, rd_en, dp_clr, busy} !== {3'd0, 3'd0, 3'b111}) begin
                    errors++;
                    $display("FAIL basic_fetch_a got a=%0d b=%0d rd=%b clr=%b busy=%b, expected 0 0 1 1 1", a_addr, b_addr, rd_en, dp_clr, busy);
                end
            end
            if (rel == 2) begin
                checks++;
                if ({a_addr, b_addr, rd_en, dp_clr} !== {3'd1, 3'd1, 2'b10}) begin
                    errors++;
                    $display("FAIL basic_fetch_b got a=%0d b=%0d rd=%b clr=%b, expected 1 1 1 0", a_addr, b_addr, rd_en, dp_clr);
                end
            end
            if (rel == 6) begin
                checks++;
                if ({wr_en, wr_tile, wr_data} !== {1'b1, 4'd0, 32'h13162B32}) begin
                    errors++;
                    $display("FAIL basic_write got en=%b tile=%0d data=%h, expected 1 0 13162b32", wr_en, wr_tile, wr_data);
                end
            end
            if (rel == 7) begin
                checks++;
                if ({done, ovf_flag, wr_en} !== 3'b100) begin
                    errors++;
                    $display("FAIL basic_done got done=%b ovf_flag=%b wr_en=%b, expected 1 0 0", done, ovf_flag, wr_en);
                end
            end
            if (rel == 8) begin
                checks++;
                if ({busy, done} !== 2'b00) begin
                    errors++;
                    $display("FAIL basic_idle got busy=%b done=%b, expected 0 0", busy, done);
                end
            end
        end
        checks++;
        if (wr_cnt - w0 != 1 || last_wr_data !== 32'h13162B32) begin
            errors++;
            $display("FAIL basic_count got writes=%0d last=%h, expected 1 13162b32", wr_cnt - w0, last_wr_data);
        end
    endtask

    task automatic test_full(input int n, input bit ident, input bit hold, input int exp_done);
        int fw, da, nw, t;
        t = (n + 1) / 2;
        if (ident) begin
            for (int r = 0; r < 5; r++)
                for (int k = 0; k < 5; k++) begin
                    ma[r][k] = (r == k) ? 1 : 0;
                    mb[r][k] = (r == k) ? 1 : 0;
                end
        end else begin
            fill_rand(n);
        end
        load_mem(n);
        exp_ovf = 1'b0;
        push_exp(n, 9);
        run_op(n, hold, fw, da, nw);
        checks++;
        if (da != exp_done || nw != t * t) begin
            errors++;
            $display("FAIL full_n%0d got done_at=%0d writes=%0d, expected %0d %0d", n, da, nw, exp_done, t * t);
        end
        checks++;
        if (sb.size() != 0 || ovf_flag !== exp_ovf) begin
            errors++;
            $display("FAIL full_n%0d_end got pending=%0d ovf_flag=%b, expected 0 %b", n, sb.size(), ovf_flag, exp_ovf);
        end
        sb.delete();
    endtask

    task automatic test_ovf;
        int fw, da, nw;
        for (int r = 0; r < 5; r++)
            for (int k = 0; k < 5; k++) begin
                ma[r][k] = (r < 2 && k < 2) ? 100 : 0;
                mb[r][k] = (r < 2 && k < 2) ? 100 : 0;
            end
        load_mem(2);
        exp_ovf = 1'b0;
        push_exp(2, 9);
        run_op(2, 1'b0, fw, da, nw);
        checks++;
        if (da != 7 || ovf_flag !== 1'b1 || exp_ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set got done_at=%0d ovf_flag=%b, expected 7 1", da, ovf_flag);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (ovf_flag !== 1'b1) begin
            errors++;
            $display("FAIL ovf_held got %b, expected 1", ovf_flag);
        end
    endtask

    task automatic test_err;
        int bad[4] = '{0, 1, 6, 7};
        for (int i = 0; i < 4; i++) begin
            start = 1'b1;
            size = 3'(bad[i]);
            #1;
            checks++;
            if ({err, busy} !== 2'b10) begin
                errors++;
                $display("FAIL err_pulse size=%0d got err=%b busy=%b, expected 1 0", bad[i], err, busy);
            end
            @(negedge clk);
            start = 1'b0;
            #1;
            checks++;
            if ({err, busy, ovf_flag} !== 3'b001) begin
                errors++;
                $display("FAIL err_after size=%0d got err=%b busy=%b ovf_flag=%b, expected 0 0 1", bad[i], err, busy, ovf_flag);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_abort(input int n, input int abort_rel, input int nexp);
        int w0, seen_done;
        fill_rand(n);
        load_mem(n);
        exp_ovf = 1'b0;
        push_exp(n, nexp);
        w0 = wr_cnt;
        seen_done = 0;
        start = 1'b1;
        size = 3'(n);
        for (int rel = 1; rel <= 80; rel++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            if (done) seen_done++;
            if (rel == abort_rel) abort = 1'b1;
            if (rel == abort_rel + 1) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL abort_idle rel=%0d got busy=%b, expected 0", abort_rel, busy);
                end
            end
        end
        checks++;
        if (wr_cnt - w0 != nexp || seen_done != 0 || sb.size() != 0) begin
            errors++;
            $display("FAIL abort_count rel=%0d got writes=%0d done=%0d pending=%0d, expected %0d 0 0", abort_rel, wr_cnt - w0, seen_done, sb.size(), nexp);
        end
        sb.delete();
    endtask

    task automatic test_reset_mid;
        int w0, seen_done;
        w0 = wr_cnt;
        seen_done = 0;
        start = 1'b1;
        size = 3'd2;
        repeat (2) @(negedge clk);
        start = 1'b0;
        checks++;
        if (rd_en !== 1'b1 || a_addr !== 3'd1) begin
            errors++;
            $display("FAIL rstmid_fetch_b got rd=%b a=%0d, expected 1 1", rd_en, a_addr);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({busy, done, err, rd_en, wr_en, dp_clr, ovf_flag, a_addr, b_addr, wr_tile, wr_data} !== 49'b0 || {lin, col} !== 160'b0) begin
            errors++;
            $display("FAIL rstmid_outputs got busy=%b rd=%b a=%0d b=%0d lin=%h, expected all 0", busy, rd_en, a_addr, b_addr, lin);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        checks++;
        if (wr_cnt - w0 != 0 || seen_done != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_quiet got writes=%0d done=%0d busy=%b, expected 0 0 0", wr_cnt - w0, seen_done, busy);
        end
    endtask

    initial begin
        for (int r = 0; r < 5; r++)
            for (int k = 0; k < 5; k++) begin
                ma[r][k] = 0;
                mb[r][k] = 0;
            end
        exp_ovf = 1'b0;
        last_wr_data = '0;
        test_reset;
        test_basic;
        test_full(5, 1'b1, 1'b0, 55);
        test_full(3, 1'b0, 1'b0, 25);
        test_ovf;
        test_err;
        test_full(4, 1'b0, 1'b1, 25);
        test_full(2, 1'b0, 1'b0, 7);
        test_abort(5, 16, 2);
        test_abort(3, 6, 1);
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_seq.md
MULT_SEQ -- requirements
Module: mult_seq

Interface
REQ-001 SHALL have parameter MULT_LAT, default 2: cycles the 2x2 tile datapath needs from stable lin/col to valid n_out/ovf (1..7).
REQ-002 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports start in 1 (begin multiply), abort in 1 (cancel), size in 3 (matrix dimension N, legal 2..5).
REQ-005 SHALL have ports busy out 1, done out 1 (one-cycle pulse), err out 1 (one-cycle pulse), ovf_flag out 1 (sticky overflow).
REQ-006 SHALL have ports a_addr out 3 (M1 row index), b_addr out 3 (M2 column index), rd_en out 1, a_data in 40, b_data in 40 (5 x int8, synchronous read, 1-cycle latency).
REQ-007 SHALL have ports lin out 80, col out 80, dp_clr out 1 (datapath clear pulse), n_out in 32, ovf in 1 (to/from tile datapath).
REQ-008 SHALL have ports wr_en out 1, wr_tile out 4 (tile index), wr_data out 32 (result tile {c00,c01,c10,c11}).

Function
REQ-009 SHALL implement FSM states IDLE, FETCH_A, FETCH_B, LOAD, WAIT, WRITE, DONE; busy=1 in every state except IDLE.
REQ-010 SHALL in IDLE accept start when size in 2..5: latch size, clear ovf_flag, rp=cp=0, go to FETCH_A next cycle.
REQ-011 SHALL in IDLE on start with size outside 2..5: stay IDLE, pulse err one cycle, leave ovf_flag unchanged.
REQ-012 SHALL ignore start in all non-IDLE states.
REQ-013 SHALL iterate tiles row-pair-major: rp 0..ceil(N/2)-1 outer, cp 0..ceil(N/2)-1 inner; wr_tile = rp*3+cp.
REQ-014 SHALL in FETCH_A drive a_addr=2rp, b_addr=2cp, rd_en=1, dp_clr=1.
REQ-015 SHALL in FETCH_B capture a_data into lin[79:40], b_data into col[79:40]; drive a_addr=2rp+1, b_addr=2cp+1, rd_en=1.
REQ-016 SHALL in LOAD capture a_data into lin[39:0], b_data into col[39:0], substituting 40'h0 for any half whose index >= N.
REQ-017 SHALL zero element bytes at positions >= N inside every captured row/column (byte 0 = bits [39:32]).
REQ-018 SHALL hold lin/col stable from LOAD exit until WRITE exit; WAIT lasts exactly MULT_LAT cycles (counter).
REQ-019 SHALL in WRITE assert wr_en=1 for one cycle with wr_data=n_out, OR ovf into ovf_flag, then advance cp (wrap to 0, increment rp).
REQ-020 SHALL after the last tile's WRITE enter DONE: done=1 one cycle, then IDLE.
REQ-021 SHALL take 4+MULT_LAT cycles per tile; start-accept edge to done = ceil(N/2)^2*(4+MULT_LAT)+1 cycles.
REQ-022 SHALL on abort in any non-IDLE state return to IDLE next cycle, with no further wr_en and no done; ovf_flag retained.
REQ-023 SHALL give abort priority over WRITE in the same cycle (that wr_en still asserts; no later one).
REQ-024 SHALL keep rd_en, wr_en, dp_clr, done, err at 0 outside the states named above.

Reset
REQ-025 SHALL on rst low asynchronously force IDLE, busy=done=err=rd_en=wr_en=dp_clr=0, ovf_flag=0, lin=col=0, a_addr=b_addr=0, wr_tile=0, wr_data=0, counters=0.
REQ-026 SHALL, if reset asserts mid-operation, produce no wr_en or done after release until a new start.

Verification
REQ-027 SHALL cover N=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], MULT_LAT=2, start at cycle 0 -> wr_en at cycle 6, wr_tile=0, wr_data=32'h13162B32, done at cycle 7, ovf_flag=0.
REQ-028 SHALL cover N=5, A=B=identity -> 9 writes, wr_tile 0..8 in order, diagonal tile bytes 1, done at cycle 55.
REQ-029 SHALL cover N=3 -> 4 writes, wr_tile 0,1,3,4; padded bytes in wr_data are 0; done at cycle 25.
REQ-030 SHALL cover N=2, all elements 100 with model ovf=1 -> ovf_flag=1 after WRITE, held after done, cleared by next accepted start.
REQ-031 SHALL cover abort asserted in WAIT of tile 2 (N=5) -> IDLE next cycle, exactly 2 writes total, no done.
REQ-032 SHALL cover start with size=6 -> err pulse one cycle, busy stays 0; rst low during FETCH_B -> all outputs per REQ-025 within same cycle.
